// File: rtl/counter_load_preset.sv
`default_nettype none
// ============================================================================
// Module      : counter_load_preset
// Description : Free-running up-counter with synchronous preset-to-all-ones
//               and synchronous parallel load. Priority on each rising edge
//               while clear is high: pre > en > increment.
//
// Parameters  : WIDTH    - counter/data width in bits (>= 2), default 4
//
// Ports       : clk      - system clock, rising-edge active
//               clear    - asynchronous active-low clear (0 forces count to 0)
//               pre      - synchronous preset to all ones, active-high
//               en       - synchronous parallel-load enable, active-high
//               data_in  - load value, sampled when en = 1 and pre = 0
//               data_out - current count, registered
//               tc       - terminal count, 1 while data_out is all ones
//
// Options     : COUNTER_LOAD_PRESET_SAT_EN - when defined, the increment path
//               saturates at all ones instead of wrapping to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module counter_load_preset #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             pre,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_inc;
    logic             w_at_top;

    assign w_at_top = (r_count == c_all_ones);

`ifdef COUNTER_LOAD_PRESET_SAT_EN
    // Saturating increment: once at all ones, only clear, pre or en move it.
    assign w_count_inc = w_at_top ? r_count : (r_count + c_one);
`else
    // Wrapping increment: all ones rolls over to zero.
    assign w_count_inc = r_count + c_one;
`endif

    // data_in only reaches the register on the load branch, so an unknown
    // data_in cannot disturb the count unless a load is actually selected.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_count <= '0;
        end else if (pre) begin
            r_count <= c_all_ones;
        end else if (en) begin
            r_count <= data_in;
        end else begin
            r_count <= w_count_inc;
        end
    end

    assign data_out = r_count;
    assign tc       = w_at_top;

endmodule
`default_nettype wire

// File: tb/tb_counter_load_preset.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_load_preset
// Description : Directed self-checking bench for counter_load_preset at the
//               default width of 4. Expected values are hand-computed
//               constants; each comparison is an immediate assertion.
//               Builds with or without COUNTER_LOAD_PRESET_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_load_preset;

    localparam int WIDTH = 4;

    logic             clk;
    logic             clear;
    logic             pre;
    logic             en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             tc;

    int total;
    int bad;

    counter_load_preset #(
        .WIDTH    (WIDTH)
    ) dut (
        .clk      (clk),
        .clear    (clear),
        .pre      (pre),
        .en       (en),
        .data_in  (data_in),
        .data_out (data_out),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare count and terminal-count outputs against expected values.
    task automatic chk(input string tag, input logic [WIDTH-1:0] exp_cnt, input logic exp_tc);
        total++;
        assert (data_out === exp_cnt) else begin
            bad++;
            $error("FAIL %s data_out observed=%h expected=%h", tag, data_out, exp_cnt);
        end
        total++;
        assert (tc === exp_tc) else begin
            bad++;
            $error("FAIL %s tc observed=%b expected=%b", tag, tc, exp_tc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [WIDTH-1:0] exp_v;
        total   = 0;
        bad     = 0;
        clear   = 1'b0;
        pre     = 1'b0;
        en      = 1'b0;
        data_in = '0;

        // Reset state and hold while clear is low.
        #1;
        chk("reset_state", 4'h0, 1'b0);
        tick();
        tick();
        chk("reset_hold", 4'h0, 1'b0);

        // Release clear mid-cycle; count 1, 2, 3.
        clear = 1'b1;
        tick(); chk("post_reset_1", 4'h1, 1'b0);
        tick(); chk("post_reset_2", 4'h2, 1'b0);
        tick(); chk("post_reset_3", 4'h3, 1'b0);

        // Asynchronous clear mid-cycle while counting.
        #2;
        clear = 1'b0;
        #1;
        chk("async_clear", 4'h0, 1'b0);
        #1;
        clear = 1'b1;
        tick(); chk("after_clear_1", 4'h1, 1'b0);
        tick(); chk("after_clear_2", 4'h2, 1'b0);
        tick(); chk("after_clear_3", 4'h3, 1'b0);

        // pre at count 3 -> all ones.
        pre = 1'b1;
        tick(); chk("preset", 4'hF, 1'b1);
        pre = 1'b0;
`ifdef COUNTER_LOAD_PRESET_SAT_EN
        tick(); chk("preset_then_hold", 4'hF, 1'b1);
`else
        tick(); chk("preset_then_wrap", 4'h0, 1'b0);

        // Free run from 0 for 16 edges: 1..F then 0, tc only at F.
        for (int i = 1; i <= 16; i++) begin
            exp_v = WIDTH'(i);
            tick();
            chk($sformatf("free_run_%0d", i), exp_v, (exp_v == 4'hF));
        end
`endif

        // Parallel load of 5, then counting 6, 7.
        en      = 1'b1;
        data_in = 4'h5;
        tick(); chk("load_5", 4'h5, 1'b0);
        en      = 1'b0;
        data_in = 4'h0;
        tick(); chk("load_then_6", 4'h6, 1'b0);
        tick(); chk("load_then_7", 4'h7, 1'b0);

        // pre and en together: pre wins.
        pre     = 1'b1;
        en      = 1'b1;
        data_in = 4'hA;
        tick(); chk("pre_over_en", 4'hF, 1'b1);

        // Held en reloads every edge.
        pre     = 1'b0;
        data_in = 4'h9;
        tick(); chk("held_en_1", 4'h9, 1'b0);
        tick(); chk("held_en_2", 4'h9, 1'b0);

        // Held pre repeats the preset.
        en  = 1'b0;
        pre = 1'b1;
        tick(); chk("held_pre_1", 4'hF, 1'b1);
        tick(); chk("held_pre_2", 4'hF, 1'b1);
        pre = 1'b0;

        // Unknown data_in must not leak into the count when not loading.
        en      = 1'b1;
        data_in = 4'h2;
        tick(); chk("load_2", 4'h2, 1'b0);
        en      = 1'b0;
        data_in = 'x;
        tick(); chk("x_data_ignored_3", 4'h3, 1'b0);
        tick(); chk("x_data_ignored_4", 4'h4, 1'b0);
        data_in = 4'h0;

        // Increment past all ones from 0xD.
        en      = 1'b1;
        data_in = 4'hD;
        tick(); chk("load_d", 4'hD, 1'b0);
        en      = 1'b0;
        tick(); chk("count_e", 4'hE, 1'b0);
        tick(); chk("count_f", 4'hF, 1'b1);
`ifdef COUNTER_LOAD_PRESET_SAT_EN
        tick(); chk("sat_hold_1", 4'hF, 1'b1);
        tick(); chk("sat_hold_2", 4'hF, 1'b1);
        en      = 1'b1;
        data_in = 4'h2;
        tick(); chk("sat_leave_load", 4'h2, 1'b0);
        en      = 1'b0;
        tick(); chk("sat_leave_count", 4'h3, 1'b0);
`else
        tick(); chk("wrap_0", 4'h0, 1'b0);
        tick(); chk("wrap_1", 4'h1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
